// File: rtl/load_store_unit_if.sv
// Request/response handshake between the MEM stage and the load/store unit,
// plus the word-wide DataMemory bus that the unit drives.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] readData;

  // Pipeline and DataMemory side
  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output readData,
    input  req_ready, resp_valid, load_data, misaligned,
    input  address, writeData, MemRead, MemWrite
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  readData,
    output req_ready, resp_valid, load_data, misaligned,
    output address, writeData, MemRead, MemWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS sub-word load/store unit: lane extraction, sign/zero extension,
// alignment checking and read-modify-write for sb/sh over a word-wide memory.
module load_store_unit #(
  parameter bit WORD_ADDR  = 1'b1,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

  state_t      state, state_next;
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_mis;
  logic [31:0] merged_q;
  logic [31:0] load_q;

  logic        accept;
  logic        mis_in;
  logic [4:0]  shift;
  logic [15:0] lane;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] extended;
  logic [31:0] mem_addr;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    mis_in = 1'b0;
    unique case (bus.req_size)
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = bus.req_addr[0];
      2'b10:   mis_in = |bus.req_addr[1:0];
      default: mis_in = 1'b1;
    endcase
  end

  // Bit offset of the addressed lane inside the memory word
  always_comb begin
    shift = '0;
    unique case (r_size)
      2'b00:   shift = BIG_ENDIAN ? {~r_addr[1:0], 3'b000} : {r_addr[1:0], 3'b000};
      2'b01:   shift = BIG_ENDIAN ? {~r_addr[1], 4'b0000} : {r_addr[1], 4'b0000};
      default: shift = '0;
    endcase
  end

  assign lane      = 16'(bus.readData >> shift);
  assign lane_mask = (r_size == 2'b00) ? 32'h0000_00FF :
                     (r_size == 2'b01) ? 32'h0000_FFFF : '1;
  assign merged    = (bus.readData & ~(lane_mask << shift)) |
                     ((r_wdata & lane_mask) << shift);
  assign mem_addr  = WORD_ADDR ? {2'b00, r_addr[31:2]} : {r_addr[31:2], 2'b00};

  always_comb begin
    extended = bus.readData;
    unique case (r_size)
      2'b00:   extended = r_unsigned ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   extended = r_unsigned ? {16'b0, lane} : {{16{lane[15]}}, lane};
      default: extended = bus.readData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = mis_in ? RESP : ACCESS;
      ACCESS:  state_next = (!r_store || r_size == 2'b10) ? RESP : RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // load_q is cleared on accept so stores and misaligned requests report zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_store    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mis      <= 1'b0;
      merged_q   <= '0;
      load_q     <= '0;
    end else begin
      if (accept) begin
        r_store    <= bus.req_store;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_mis      <= mis_in;
        merged_q   <= '0;
        load_q     <= '0;
      end
      if (state == ACCESS) begin
        merged_q <= merged;
        if (!r_store) load_q <= extended;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.address    = '0;
    bus.writeData  = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    unique case (state)
      ACCESS: begin
        bus.address = mem_addr;
        if (r_store && r_size == 2'b10) begin
          bus.MemWrite  = 1'b1;
          bus.writeData = r_wdata;
        end else begin
          bus.MemRead = 1'b1;
        end
      end
      RMW_WR: begin
        bus.address   = mem_addr;
        bus.MemWrite  = 1'b1;
        bus.writeData = merged_q;
      end
      default: ;
    endcase
  end

  assign bus.load_data  = load_q;
  assign bus.misaligned = r_mis;

endmodule
